// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI-Stream constants and helpers
package axis_pkg;

  localparam int AXIS_DATA_W = 128;

  // Ceiling log2; constant-evaluated for parameter arithmetic.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_keep_scan.sv
// rtl/axis_keep_scan.sv - classifies a keep vector: highest used segment, empty, contiguous
module axis_keep_scan
  import axis_pkg::*;
#(
  parameter int KEEP_W     = 16,
  parameter int SEG_KEEP_W = 4,
  parameter int SEGS       = KEEP_W / SEG_KEEP_W,
  parameter int IDX_W      = clog2(SEGS)
) (
  input  logic [KEEP_W-1:0] keep,
  output logic [IDX_W-1:0]  last_seg,
  output logic              zero,
  output logic              contig
);

  logic [KEEP_W-1:0] keep_inc;

  always_comb begin
    last_seg = '0;
    for (int k = 0; k < SEGS; k++) begin
      if (|keep[k*SEG_KEEP_W +: SEG_KEEP_W]) begin
        last_seg = IDX_W'(k);
      end
    end
  end

  // 2^n-1 patterns have no bit in common with their increment (all-ones wraps to zero).
  assign keep_inc = keep + KEEP_W'(1);
  assign zero     = ~|keep;
  assign contig   = ~|(keep & keep_inc);

endmodule

// File: rtl/axis_width_down.sv
// rtl/axis_width_down.sv - serializes wide AXI-Stream beats into narrow beats, LS slice first
module axis_width_down
  import axis_pkg::*;
#(
  parameter int IN_W       = AXIS_DATA_W,
  parameter int OUT_W      = 32,
  parameter int IN_KEEP_W  = IN_W / 8,
  parameter int OUT_KEEP_W = OUT_W / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       s_tdata,
  input  logic [IN_KEEP_W-1:0]  s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [OUT_W-1:0]      m_tdata,
  output logic [OUT_KEEP_W-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  keep_err
);

  localparam int R     = IN_W / OUT_W;
  localparam int IDX_W = clog2(R);

  logic                 hold_valid_q, hold_valid_d;
  logic [IN_W-1:0]      data_q, data_d;
  logic [IN_KEEP_W-1:0] keep_q, keep_d;
  logic                 last_q, last_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_seg_q, last_seg_d;
  logic                 keep_err_q, keep_err_d;

  logic [IDX_W-1:0]     scan_last_seg;
  logic                 scan_zero;
  logic                 scan_contig;
  logic                 at_final;
  logic                 out_hs;
  logic                 in_hs;

  logic [OUT_W-1:0]      seg_data [R];
  logic [OUT_KEEP_W-1:0] seg_keep [R];

  axis_keep_scan #(
    .KEEP_W     (IN_KEEP_W),
    .SEG_KEEP_W (OUT_KEEP_W),
    .SEGS       (R),
    .IDX_W      (IDX_W)
  ) u_keep_scan (
    .keep     (s_tkeep),
    .last_seg (scan_last_seg),
    .zero     (scan_zero),
    .contig   (scan_contig)
  );

  for (genvar g = 0; g < R; g++) begin : g_seg
    assign seg_data[g] = data_q[g*OUT_W +: OUT_W];
    assign seg_keep[g] = keep_q[g*OUT_KEEP_W +: OUT_KEEP_W];
  end

  assign at_final = (idx_q == last_seg_q);
  assign out_hs   = hold_valid_q && m_tready;
  // Refill on the same edge as the final segment leaves, so streaming has no bubble.
  assign s_tready = !hold_valid_q || (out_hs && at_final);
  assign in_hs    = s_tvalid && s_tready;

  assign m_tvalid = hold_valid_q;
  assign m_tdata  = seg_data[idx_q];
  assign m_tkeep  = seg_keep[idx_q];
  assign m_tlast  = last_q && at_final;
  assign keep_err = keep_err_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    idx_d        = idx_q;
    last_seg_d   = last_seg_q;
    keep_err_d   = keep_err_q;
    if (out_hs) begin
      if (!at_final) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        hold_valid_d = 1'b0;
      end
    end
    if (in_hs) begin
      // Empty non-final beats carry nothing; an empty final beat still marks the packet end.
      if (!scan_zero || s_tlast) begin
        hold_valid_d = 1'b1;
        data_d       = s_tdata;
        keep_d       = s_tkeep;
        last_d       = s_tlast;
        idx_d        = '0;
        last_seg_d   = scan_last_seg;
      end
      if (!scan_contig) begin
        keep_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      idx_q        <= '0;
      last_seg_q   <= '0;
      keep_err_q   <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      last_seg_q   <= last_seg_d;
      keep_err_q   <= keep_err_d;
    end
  end

endmodule

// File: tb/tb_axis_width_down.sv
// tb/tb_axis_width_down.sv - directed vectors and sequences for axis_width_down
module tb_axis_width_down;

  logic         clk;
  logic         rst_n;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tlast;
  logic         s_tvalid;
  logic         s_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic         keep_err;

  axis_width_down dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .keep_err (keep_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    int           nbeats;
    logic [127:0] ed;   // expected beat data, beat0 in the low word
    logic [15:0]  ek;   // expected beat keep, beat0 in the low nibble
    logic [3:0]   el;   // expected beat last, beat0 in bit 0
    logic         eerr;
  } vec_t;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] got_d [8];
  logic [3:0]  got_k [8];
  logic        got_l [8];
  int          got_n;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] d, input logic [15:0] k, input logic l,
                              input int n, input logic [127:0] ed, input logic [15:0] ek,
                              input logic [3:0] el, input logic eerr);
    vec_t v;
    v.data = d; v.keep = k; v.last = l; v.nbeats = n;
    v.ed = ed; v.ek = ek; v.el = el; v.eerr = eerr;
    return v;
  endfunction

  function automatic logic [31:0] sw(input int i, input int j);
    return {8'(i), 8'(j), 16'hC0DE};
  endfunction

  task automatic send_one(input logic [127:0] d, input logic [15:0] k, input logic l);
    int g;
    g = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("send_ready", s_tready, 1'b1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    got_n = 0;
    m_tready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (m_tvalid && got_n < 8) begin
        got_d[got_n] = m_tdata;
        got_k[got_n] = m_tkeep;
        got_l[got_n] = m_tlast;
        got_n++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_stream(input int base, input bit rnd);
    fork
      begin : drv
        for (int i = 0; i < 8; i++) begin
          bit taken;
          int guard;
          s_tdata  = {sw(base+i, 3), sw(base+i, 2), sw(base+i, 1), sw(base+i, 0)};
          s_tkeep  = 16'hFFFF;
          s_tlast  = (i == 7);
          s_tvalid = 1'b1;
          taken = 1'b0;
          guard = 0;
          while (!taken && guard < 200) begin
            #1;
            taken = s_tready;
            @(posedge clk); #1;
            guard++;
          end
          chk($sformatf("stream%0d_accept%0d", base, i), taken, 1'b1);
        end
        s_tvalid = 1'b0;
      end
      begin : mon
        int got, cyc, first, lastc;
        logic stall_prev;
        logic [36:0] prev;
        got = 0; cyc = 0; first = -1; lastc = -1; stall_prev = 1'b0; prev = '0;
        while (got < 32 && cyc < 400) begin
          m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          #1;
          if (stall_prev) begin
            chk("stall_valid", m_tvalid, 1'b1);
            chk("stall_hold", {m_tlast, m_tkeep, m_tdata}, prev);
          end
          if (m_tvalid && m_tready) begin
            if (first < 0) first = cyc;
            lastc = cyc;
            chk($sformatf("stream%0d_data%0d", base, got), m_tdata, sw(base + got/4, got%4));
            chk($sformatf("stream%0d_keep%0d", base, got), m_tkeep, 4'hF);
            chk($sformatf("stream%0d_last%0d", base, got), m_tlast, (got == 31));
            got++;
          end
          stall_prev = m_tvalid && !m_tready;
          prev = {m_tlast, m_tkeep, m_tdata};
          @(posedge clk); #1;
          cyc++;
        end
        chk($sformatf("stream%0d_count", base), got, 32);
        if (!rnd) chk("stream_nobubble", lastc - first, 31);
        m_tready = 1'b1;
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast",  m_tlast,  1'b0);
    chk("rst_m_tkeep",  m_tkeep,  4'h0);
    chk("rst_m_tdata",  m_tdata,  32'h0);
    chk("rst_s_tready", s_tready, 1'b1);
    chk("rst_keep_err", keep_err, 1'b0);

    vecs[0] = mk(D1, 16'hFFFF, 1'b1, 4, {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}, 16'hFFFF, 4'b1000, 1'b0);
    vecs[1] = mk(D2, 16'h003F, 1'b1, 2, {32'h0, 32'h0, 32'hFEDCBA98, 32'h76543210}, 16'h003F, 4'b0010, 1'b0);
    vecs[2] = mk(D2, 16'h0000, 1'b0, 0, 128'h0, 16'h0000, 4'b0000, 1'b0);
    vecs[3] = mk(D2, 16'h0000, 1'b1, 1, {32'h0, 32'h0, 32'h0, 32'h76543210}, 16'h0000, 4'b0001, 1'b0);
    vecs[4] = mk(D3, 16'h0001, 1'b1, 1, {32'h0, 32'h0, 32'h0, 32'hCAFEF00D}, 16'h0001, 4'b0001, 1'b0);
    vecs[5] = mk(D1, 16'h00F0, 1'b1, 2, {32'h0, 32'h0, 32'h8899AABB, 32'hCCDDEEFF}, 16'h00F0, 4'b0010, 1'b1);
    vecs[6] = mk(D3, 16'hFFFF, 1'b0, 4, {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hDEADBEEF, 32'hCAFEF00D}, 16'hFFFF, 4'b0000, 1'b1);
    vecs[7] = mk(D1, 16'h0FFF, 1'b1, 3, {32'h0, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}, 16'h0FFF, 4'b0100, 1'b1);
    vecs[8] = mk(D2, 16'h1000, 1'b1, 4, {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210}, 16'h1000, 4'b1000, 1'b1);

    for (int i = 0; i < 9; i++) begin
      send_one(vecs[i].data, vecs[i].keep, vecs[i].last);
      collect(6);
      chk($sformatf("v%0d_count", i), got_n, vecs[i].nbeats);
      for (int b = 0; b < vecs[i].nbeats && b < got_n; b++) begin
        chk($sformatf("v%0d_b%0d_data", i, b), got_d[b], vecs[i].ed[b*32 +: 32]);
        chk($sformatf("v%0d_b%0d_keep", i, b), got_k[b], vecs[i].ek[b*4 +: 4]);
        chk($sformatf("v%0d_b%0d_last", i, b), got_l[b], vecs[i].el[b]);
      end
      chk($sformatf("v%0d_keep_err", i), keep_err, vecs[i].eerr);
    end

    run_stream(0, 1'b0);
    run_stream(8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("stream_idle_valid", m_tvalid, 1'b0);
    chk("stream_keep_err", keep_err, 1'b1);

    send_one(D1, 16'hFFFF, 1'b1);
    collect(2);
    chk("rstmid_pre_count", got_n, 2);
    chk("rstmid_pre_b1", got_d[1], 32'h8899AABB);
    rst_n = 1'b0;
    #1;
    chk("rstmid_m_tvalid", m_tvalid, 1'b0);
    chk("rstmid_s_tready", s_tready, 1'b1);
    chk("rstmid_m_tdata",  m_tdata,  32'h0);
    chk("rstmid_m_tkeep",  m_tkeep,  4'h0);
    chk("rstmid_m_tlast",  m_tlast,  1'b0);
    chk("rstmid_keep_err", keep_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    collect(3);
    chk("rstmid_no_partial", got_n, 0);
    send_one(D3, 16'hFFFF, 1'b1);
    collect(6);
    chk("rstmid_post_count", got_n, 4);
    chk("rstmid_post_b0", got_d[0], 32'hCAFEF00D);
    chk("rstmid_post_b1", got_d[1], 32'hDEADBEEF);
    chk("rstmid_post_b2", got_d[2], 32'h5A5A5A5A);
    chk("rstmid_post_b3", {got_l[3], got_k[3], got_d[3]}, {1'b1, 4'hF, 32'hA5A5A5A5});
    chk("rstmid_post_b0_last", got_l[0], 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_width_down.md
# axis_width_down

Stream width down-converter. It sits downstream of `axis_fifo` and drains the wide 128-bit AES block stream into a narrower AXI-Stream, typically toward a 32-bit DMA or host port. Each accepted wide beat is serialized into up to `IN_W/OUT_W` narrow beats, least-significant slice first, and `tkeep`/`tlast` framing is preserved.

## Interface
Parameters:
- `IN_W`, default 128: input data width, in bits.
- `OUT_W`, default 32: output data width, in bits. `IN_W/OUT_W` must be an integer power of two, at least 2.
- `IN_KEEP_W`, default `IN_W/8`: input keep width.
- `OUT_KEEP_W`, default `OUT_W/8`: output keep width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `s_tdata`, in, `IN_W`: wide input data.
- `s_tkeep`, in, `IN_KEEP_W`: byte enables for the input beat.
- `s_tlast`, in, 1: end of packet.
- `s_tvalid`, in, 1: input valid.
- `s_tready`, out, 1: input ready.
- `m_tdata`, out, `OUT_W`: narrow output data.
- `m_tkeep`, out, `OUT_KEEP_W`: byte enables for the output beat.
- `m_tlast`, out, 1: end of packet.
- `m_tvalid`, out, 1: output valid.
- `m_tready`, in, 1: output ready.
- `keep_err`, out, 1: sticky flag. Set when an input beat carries non-contiguous keep.

## Operation
- Segment definitions:
  - R = `IN_W/OUT_W`.
  - Segment k of a beat is data bits `[k*OUT_W +: OUT_W]` and keep bits `[k*OUT_KEEP_W +: OUT_KEEP_W]`.
- State:
  - `hold_valid`.
  - Holding registers: data, keep, last.
  - Segment index `idx`, range 0..R-1.
  - `last_seg`, range 0..R-1.
- On input handshake (`s_tvalid && s_tready`):
  - If keep is nonzero: capture data, keep and last. Set `idx`=0. Set `last_seg` = index of the segment containing the highest set keep bit. Set `hold_valid`=1.
  - If keep == 0 and `s_tlast`=0: consume the beat and drop it. `hold_valid` stays 0.
  - If keep == 0 and `s_tlast`=1: capture with `last_seg`=0. This emits exactly one beat with `m_tkeep`=0 and `m_tlast`=1, so packet framing is preserved.
- Output mapping:
  - `m_tvalid` = `hold_valid`.
  - `m_tdata` and `m_tkeep` = segment `idx` of the held beat.
  - `m_tlast` = held last AND (`idx == last_seg`).
- On output handshake:
  - If `idx < last_seg`: `idx` increments.
  - Otherwise: `hold_valid` clears, unless a new beat is captured in the same cycle.
- Segments above `last_seg` are never emitted.
- Segments between 0 and `last_seg` are emitted verbatim, even when their keep slice is zero. This case arises only with non-contiguous keep.
- `s_tready` = !`hold_valid` OR (`m_tvalid` AND `m_tready` AND `idx == last_seg`). The combinational path from `m_tready` to `s_tready` is intentional.
- `keep_err`:
  - Set when an accepted beat's keep is not of the form 2^n−1, for n in 0..`IN_KEEP_W`.
  - Cleared only by reset.
  - The data in that beat is still forwarded per the rules above.

## Timing
- Reset values:
  - `m_tvalid`=0, `m_tlast`=0, `m_tkeep`=0, `m_tdata`=0 (held registers cleared).
  - `s_tready`=1.
  - `keep_err`=0.
  - `idx`=0.
- Latency: a beat accepted at edge N produces its first output beat valid in the cycle after edge N.
- Throughput:
  - A full-keep beat takes R cycles with `m_tready` held at 1.
  - Back-to-back input beats cause no bubble: the next beat is accepted on the same edge as the final segment handshake.
- AXIS rules:
  - `m_tdata`, `m_tkeep` and `m_tlast` are stable while `m_tvalid && !m_tready`.
  - `m_tvalid` never deasserts without a handshake.
- Simultaneous final-segment handshake and input handshake: the new beat loads with `idx`=0, and `hold_valid` stays 1.
- Reset asserted mid-packet:
  - Outputs return to reset values immediately, with no partial emission afterward.
  - The upstream packet is truncated; recovery is the system's responsibility.

## Structure
- Shared package `axis_pkg` holds:
  - the `clog2` function (shared with `axis_fifo`);
  - the `AXIS_DATA_W`=128 constant.
- One combinational sub-module, `axis_keep_scan`. Input: keep vector. Outputs: `last_seg` (index of the highest nonzero segment), `zero` (keep == 0), and `contig` (keep is of the form 2^n−1).
- The top level contains only the holding registers, the index counter and the output mux.

## Test plan
- Full beat: keep=0xFFFF, tlast=1, data=0x00112233_44556677_8899AABB_CCDDEEFF.
  - Expect beats 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233, each with keep=0xF.
  - `m_tlast` on the 4th beat only.
- Partial beat: keep=0x003F, tlast=1.
  - Expect 2 beats: keep 0xF, then keep 0x3.
  - `m_tlast` on the 2nd beat.
  - `keep_err` stays 0.
- Streaming: 8 full beats, `m_tvalid`/`m_tready` held high.
  - Expect 32 consecutive output beats with no bubble.
  - Then randomize `m_tready` at 50%: output data stays stable under stall, and ordering is unchanged.
- Zero keep:
  - keep=0, tlast=0: dropped, no output.
  - keep=0, tlast=1: exactly one beat with keep=0, last=1.
- Non-contiguous keep: keep=0x00F0.
  - Expect 2 beats: keep 0x0, then keep 0xF, with last on the 2nd.
  - `keep_err` rises and stays 1 through later clean beats.
- Reset mid-packet: assert `rst_n`=0 after the 2nd output beat of a full beat.
  - Expect `m_tvalid`=0 and `s_tready`=1 immediately.
  - After release, a new packet is emitted correctly from segment 0.
